// File: rtl/wb_master_arbiter_pkg.sv
// wb_arb_pkg: Wishbone widths, timeout fill pattern and arbiter FSM encoding.
package wb_arb_pkg;
   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;
   localparam logic [WB_DAT_W-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;
   typedef enum logic {IDLE, OWNED} state_t;
endpackage

// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: per-master Wishbone requests, the shared slave-side port and arbiter status.
interface wb_master_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0]          m_cyc_i, m_stb_i, m_we_i, m_ack_o, grant_o;
   logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i;
   logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i, m_dat_o;
   logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i;
   logic                            s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
   logic [WB_ADR_W-1:0]             s_adr_o;
   logic [WB_DAT_W-1:0]             s_dat_o, s_dat_i;
   logic [WB_SEL_W-1:0]             s_sel_o;
   modport master (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
      output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o, timeout_o
   );
   modport slave (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
      input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o, timeout_o
   );
endinterface

// File: rtl/wb_master_arbiter_rr_picker.sv
// wb_rr_picker: picks the first request after ptr, wrapping modulo N; one-hot grant plus valid.
module wb_rr_picker #(
   parameter int N = 2,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic         valid
);
   logic [W-1:0] k;
   // scan farthest-first so the nearest requester after ptr overwrites last
   always_comb begin
      gnt = '0;
      k = '0;
      for (int i = N; i >= 1; i--) begin
         k = W'((int'(ptr) + i) % N);
         if (req[k]) gnt = N'(1) << k;
      end
   end
   assign valid = |req;
endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin sharing of one Wishbone master port among NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to force-terminate cycles left unacked for TIMEOUT_CYCLES stall cycles.
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                 clk,
   input logic                 rst,
   wb_master_arbiter_if.master bus
);
   localparam int PW = $clog2(NUM_MASTERS);
   state_t                 state, state_n;
   logic [NUM_MASTERS-1:0] grant, grant_n, pick;
   logic [PW-1:0]          ptr, ptr_n, own;
   logic                   pick_valid, own_cyc, own_stb, tmo;
   wb_rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req(bus.m_cyc_i), .ptr(ptr), .gnt(pick), .valid(pick_valid)
   );
   // grant is all-zero while idle, so the mux naturally parks the slave side at zero
   always_comb begin
      own = '0;
      own_cyc = 1'b0;
      own_stb = 1'b0;
      bus.s_we_o = 1'b0;
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++)
         if (grant[k]) begin
            own = PW'(k);
            own_cyc = bus.m_cyc_i[k];
            own_stb = bus.m_stb_i[k];
            bus.s_we_o = bus.m_we_i[k];
            bus.s_adr_o = bus.m_adr_i[WB_ADR_W*k +: WB_ADR_W];
            bus.s_dat_o = bus.m_dat_i[WB_DAT_W*k +: WB_DAT_W];
            bus.s_sel_o = bus.m_sel_i[WB_SEL_W*k +: WB_SEL_W];
         end
   end
`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt;
   logic          stall;
   assign stall = own_cyc && own_stb && !bus.s_ack_i;
   assign tmo = stall && cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (stall && !tmo) ? cnt + CW'(1) : '0;
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      bus.m_ack_o = '0;
      bus.m_dat_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         bus.m_ack_o[k] = grant[k] && (bus.s_ack_i || tmo);
         bus.m_dat_o[WB_DAT_W*k +: WB_DAT_W] = grant[k] ? (tmo ? TIMEOUT_FILL : bus.s_dat_i) : '0;
      end
   end
   assign bus.s_cyc_o = own_cyc && !tmo;
   assign bus.s_stb_o = own_stb && !tmo;
   assign bus.grant_o = grant;
   assign bus.timeout_o = tmo;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr <= PW'(NUM_MASTERS - 1);
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr <= ptr_n;
      end
   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n = ptr;
      if (state == IDLE && pick_valid) begin
         state_n = OWNED;
         grant_n = pick;
      end else if (state == OWNED && (!own_cyc || tmo)) begin
         state_n = IDLE;
         grant_n = '0;
         ptr_n = own;
      end
   end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed plus randomized checks of wb_master_arbiter against a transaction-level model.
// Define WB_ARB_TIMEOUT_EN to also exercise the timeout path with TIMEOUT_CYCLES=8.
module tb_wb_master_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cyc, stb, we;
   logic [31:0] adr[2], dat[2];
   logic [3:0]  sel[2];
   logic        s_ack;
   logic [31:0] s_dat;
   int          compared = 0, mismatched = 0;
   int          mown, mlast, mstall;
   wb_master_arbiter_if #(.NUM_MASTERS(2)) bus ();
   assign bus.m_cyc_i = cyc;
   assign bus.m_stb_i = stb;
   assign bus.m_we_i  = we;
   assign bus.m_adr_i = {adr[1], adr[0]};
   assign bus.m_dat_i = {dat[1], dat[0]};
   assign bus.m_sel_i = {sel[1], sel[0]};
   assign bus.s_ack_i = s_ack;
   assign bus.s_dat_i = s_dat;
   wb_master_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // reference: owner index (-1 idle), last owner, consecutive stall count
   task automatic model_reset();
      mown = -1;
      mlast = 1;
      mstall = 0;
   endtask
   function automatic logic mtmo();
`ifdef WB_ARB_TIMEOUT_EN
      return mown >= 0 && cyc[mown] && stb[mown] && !s_ack && mstall == TO - 1;
`else
      return 1'b0;
`endif
   endfunction
   task automatic model_edge();
      logic t;
      t = mtmo();
      if (rst) model_reset();
      else if (mown < 0) begin
         for (int i = 1; i <= 2; i++)
            if (mown < 0 && cyc[(mlast + i) % 2]) mown = (mlast + i) % 2;
      end else if (!cyc[mown] || t) begin
         mlast = mown;
         mown = -1;
         mstall = 0;
      end else mstall = (stb[mown] && !s_ack) ? mstall + 1 : 0;
   endtask
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask
   task automatic check_all(input string tag);
      logic        t, ecyc, estb, ewe;
      logic [1:0]  eg, ea;
      logic [31:0] eadr, edat;
      logic [3:0]  esel;
      logic [63:0] ed;
      #2;
      t = mtmo();
      {ecyc, estb, ewe, eadr, edat, esel, eg, ea, ed} = '0;
      if (mown >= 0) begin
         eg[mown] = 1'b1;
         ecyc = cyc[mown] && !t;
         estb = stb[mown] && !t;
         ewe = we[mown];
         eadr = adr[mown];
         edat = dat[mown];
         esel = sel[mown];
         ea[mown] = s_ack || t;
         ed[32*mown +: 32] = t ? 32'hDEAD_BEEF : s_dat;
      end
      chk({tag, ":grant"}, bus.grant_o, eg);
      chk({tag, ":s_cyc"}, bus.s_cyc_o, ecyc);
      chk({tag, ":s_stb"}, bus.s_stb_o, estb);
      chk({tag, ":s_we"}, bus.s_we_o, ewe);
      chk({tag, ":s_adr"}, bus.s_adr_o, eadr);
      chk({tag, ":s_dat"}, bus.s_dat_o, edat);
      chk({tag, ":s_sel"}, bus.s_sel_o, esel);
      chk({tag, ":m_ack"}, bus.m_ack_o, ea);
      chk({tag, ":m_dat"}, bus.m_dat_o, ed);
      chk({tag, ":timeout"}, bus.timeout_o, t);
   endtask
   task automatic reset_dut();
      cycle();
      rst = 1'b1;
      model_reset();
      cyc = '0;
      stb = '0;
      s_ack = 1'b0;
      check_all("rst_hold");
      cycle();
      rst = 1'b0;
      check_all("rst_rel");
   endtask
   initial begin
      logic [1:0]  order[4];
      logic [1:0]  prevg, ga;
      logic [31:0] got[3];
      int          ngr, nack;
      logic        seen;
      rst = 1'b1;
      {cyc, stb, we, s_ack, s_dat} = '0;
      adr = '{32'h0, 32'h0};
      dat = '{32'h0, 32'h0};
      sel = '{4'h0, 4'h0};
      model_reset();
      #1;
      check_all("reset");
      cycle();
      rst = 1'b0;
      check_all("post_reset");
      // single master write, slave acks two cycles after grant
      cycle();
      cyc = 2'b01; stb = 2'b01; we = 2'b01;
      adr[0] = 32'h100; dat[0] = 32'h1234_5678; sel[0] = 4'hF;
      check_all("sm_req");
      chk("sm_latency", bus.grant_o, 2'b00);
      cycle();
      check_all("sm_own");
      chk("sm_grant", bus.grant_o, 2'b01);
      chk("sm_adr", bus.s_adr_o, 32'h100);
      cycle();
      check_all("sm_wait");
      cycle();
      s_ack = 1'b1;
      check_all("sm_ack");
      chk("sm_ack_m0", bus.m_ack_o, 2'b01);
      cycle();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      check_all("sm_rel");
      chk("sm_rel_cyc", bus.s_cyc_o, 1'b0);
      cycle();
      check_all("sm_idle");
      // both masters keep requesting; each drops cyc for one cycle after its ack
      reset_dut();
      we = 2'b00;
      ngr = 0; prevg = '0; ga = '0;
      for (int c = 0; c < 40 && ngr < 4; c++) begin
         cycle();
         cyc = ~ga;
         stb = ~ga;
         s_ack = mown >= 0 && cyc[mown] && stb[mown];
         check_all("rr");
         if (bus.grant_o != 2'b00 && bus.grant_o != prevg) begin
            order[ngr] = bus.grant_o;
            ngr++;
         end
         prevg = bus.grant_o;
         for (int k = 0; k < 2; k++) ga[k] = mown == k && s_ack;
      end
      chk("rr_count", ngr, 4);
      chk("rr_order0", order[0], 2'b01);
      chk("rr_order1", order[1], 2'b10);
      chk("rr_order2", order[2], 2'b01);
      chk("rr_order3", order[3], 2'b10);
      // m0 burst of three reads while m1 waits
      reset_dut();
      we = 2'b00; nack = 0; seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         cycle();
         cyc = {1'b1, nack < 3};
         stb = {1'b1, nack < 3};
         s_dat = 32'hA + nack;
         s_ack = mown == 0 && cyc[0];
         check_all("burst");
         if (bus.grant_o[1]) begin
            seen = 1'b1;
            chk("burst_hold", nack, 3);
         end
         if (bus.m_ack_o[0] && nack < 3) begin
            got[nack] = bus.m_dat_o[31:0];
            nack++;
         end
      end
      chk("burst_m1_granted", seen, 1'b1);
      chk("burst_d0", got[0], 32'hA);
      chk("burst_d1", got[1], 32'hB);
      chk("burst_d2", got[2], 32'hC);
      // reset asserted between edges while m1 owns with stb pending
      reset_dut();
      cycle();
      cyc = 2'b10; stb = 2'b10; s_ack = 1'b0;
      check_all("mr_req");
      cycle();
      check_all("mr_own");
      chk("mr_grant_m1", bus.grant_o, 2'b10);
      cycle();
      rst = 1'b1;
      model_reset();
      cyc = 2'b11; stb = 2'b11;
      check_all("mr_async");
      chk("mr_grant0", bus.grant_o, 2'b00);
      chk("mr_ack0", bus.m_ack_o, 2'b00);
      cycle();
      check_all("mr_held");
      cycle();
      rst = 1'b0;
      check_all("mr_rel");
      cycle();
      check_all("mr_first");
      chk("mr_m0_first", bus.grant_o, 2'b01);
      // owner drops cyc in the same cycle the slave acks
      reset_dut();
      cycle();
      cyc = 2'b01; stb = 2'b01;
      check_all("co_req");
      cycle();
      cyc = 2'b11; stb = 2'b11;
      check_all("co_own");
      cycle();
      s_ack = 1'b1; cyc = 2'b10; stb = 2'b10;
      check_all("co_drop");
      chk("co_ack", bus.m_ack_o, 2'b01);
      cycle();
      s_ack = 1'b0;
      check_all("co_idle");
      chk("co_idle_grant", bus.grant_o, 2'b00);
      cycle();
      check_all("co_next");
      chk("co_next_grant", bus.grant_o, 2'b10);
      chk("co_no_stale", bus.m_ack_o, 2'b00);
`ifdef WB_ARB_TIMEOUT_EN
      // slave never acks: eighth stall cycle is forced to terminate
      reset_dut();
      cycle();
      cyc = 2'b01; stb = 2'b01; s_ack = 1'b0;
      check_all("to_req");
      for (int c = 1; c <= 8; c++) begin
         cycle();
         check_all("to_stall");
      end
      chk("to_pulse", bus.timeout_o, 1'b1);
      chk("to_ack", bus.m_ack_o, 2'b01);
      chk("to_fill", bus.m_dat_o[31:0], 32'hDEAD_BEEF);
      chk("to_cyc", bus.s_cyc_o, 1'b0);
      cycle();
      check_all("to_idle");
      chk("to_idle_grant", bus.grant_o, 2'b00);
      chk("to_idle_pulse", bus.timeout_o, 1'b0);
      cycle();
      check_all("to_regrant");
`endif
      // randomized traffic with sticky cyc
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         cycle();
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(3) == 0) cyc[k] = ~cyc[k];
            stb[k] = cyc[k] & 1'($urandom_range(1));
            we[k] = 1'($urandom_range(1));
            adr[k] = $urandom;
            dat[k] = $urandom;
            sel[k] = 4'($urandom);
         end
         s_ack = 1'($urandom_range(1));
         s_dat = $urandom;
         check_all("rnd");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
